// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous clock (sig_in) in in_clk cycles.
// Single-shot or continuous measurement with a MAX_CYC timeout abort.
module clk_period_meter #(
  parameter int unsigned      CNT_W   = 32,
  parameter logic [CNT_W-1:0] MAX_CYC = {CNT_W{1'b1}}
) (
  input  logic             in_clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_ARM  = 2'd1;
  localparam logic [ST_W-1:0] ST_MEAS = 2'd2;

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            s3_q, s3_d;
  logic [ST_W-1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic            busy_q, busy_d;

  logic rise_c;
  logic at_max_c;

  // Two-flop synchronizer plus a delay flop for rising-edge detection
  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign rise_c   = s2_q & ~s3_q;
  assign at_max_c = (cnt_q == MAX_CYC);

  // Next-state, counter and result logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
      end

      ST_ARM: begin
        if (rise_c) begin
          state_d = ST_MEAS;
          cnt_d   = CNT_W'(1);
        end else if (at_max_c) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          period_d  = '0;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_MEAS: begin
        // An edge coinciding with cnt == MAX_CYC still counts as a valid result
        if (rise_c) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          if (cont) begin
            cnt_d = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else if (at_max_c) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          period_d  = '0;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: table vectors, corner sequences and
// randomized stimulus compared every cycle against a timestamp-based reference model.
module tb_clk_period_meter;

  localparam int unsigned      CNT_W     = 16;
  localparam int unsigned      MAX_CYC   = 100;
  localparam logic [CNT_W-1:0] MAX_CYC_P = CNT_W'(MAX_CYC);
  localparam int unsigned      WAIT_LIM  = 3 * MAX_CYC + 20;

  logic             in_clk = 1'b0;
  logic             rst_n  = 1'b1;
  logic             sig_in = 1'b0;
  logic             start  = 1'b0;
  logic             cont   = 1'b0;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             timeout;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  clk_period_meter #(.CNT_W(CNT_W), .MAX_CYC(MAX_CYC_P)) dut (
    .in_clk (in_clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .start  (start),
    .cont   (cont),
    .period (period),
    .valid  (valid),
    .timeout(timeout),
    .busy   (busy)
  );

  always #5 in_clk = ~in_clk;

  // Slow clock generator: gen_hi / gen_lo in_clk cycles per phase
  bit          gen_en  = 1'b0;
  int unsigned gen_hi  = 10;
  int unsigned gen_lo  = 10;
  int unsigned gen_cnt = 0;

  always @(negedge in_clk) begin
    if (!gen_en) begin
      sig_in  = 1'b0;
      gen_cnt = 0;
    end else begin
      gen_cnt = gen_cnt + 1;
      if (gen_cnt >= (sig_in ? gen_hi : gen_lo)) begin
        sig_in  = ~sig_in;
        gen_cnt = 0;
      end
    end
  end

  // Reference model: tracks edge timestamps rather than a running counter
  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] t_ref;
    logic [1:0]  phase;   // 0 idle, 1 awaiting first edge, 2 window open
    logic [2:0]  hist;    // sig_in samples: [0] newest, [2] oldest
    logic        valid;
    logic        timeout;
    logic        busy;
    logic [31:0] period;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t cur, logic st, logic ct, logic s);
    model_t      nxt;
    logic        rise;
    logic [31:0] d;
    nxt         = cur;
    rise        = cur.hist[1] & ~cur.hist[2];
    nxt.cyc     = cur.cyc + 32'd1;
    nxt.hist    = {cur.hist[1:0], s};
    nxt.valid   = 1'b0;
    nxt.timeout = 1'b0;
    d           = nxt.cyc - cur.t_ref;
    case (cur.phase)
      2'd0: begin
        if (st) begin
          nxt.phase = 2'd1;
          nxt.t_ref = nxt.cyc;
        end
      end
      2'd1: begin
        if (rise) begin
          nxt.phase = 2'd2;
          nxt.t_ref = nxt.cyc;
        end else if (d == MAX_CYC + 1) begin
          nxt.phase   = 2'd0;
          nxt.valid   = 1'b1;
          nxt.timeout = 1'b1;
          nxt.period  = 32'd0;
        end
      end
      default: begin
        if (rise) begin
          nxt.valid  = 1'b1;
          nxt.period = d;
          if (ct) nxt.t_ref = nxt.cyc;
          else    nxt.phase = 2'd0;
        end else if (d == MAX_CYC) begin
          nxt.phase   = 2'd0;
          nxt.valid   = 1'b1;
          nxt.timeout = 1'b1;
          nxt.period  = 32'd0;
        end
      end
    endcase
    nxt.busy = (nxt.phase != 2'd0);
    return nxt;
  endfunction

  always @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, start, cont, sig_in);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Advance one cycle and compare every output against the model
  task automatic tick();
    @(negedge in_clk);
    check("model valid",   32'(valid),   32'(m.valid));
    check("model timeout", 32'(timeout), 32'(m.timeout));
    check("model busy",    32'(busy),    32'(m.busy));
    check("model period",  32'(period),  m.period);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int unsigned k);
    bit seen;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < WAIT_LIM) begin
      tick();
      k++;
      if (valid) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  typedef struct {
    int unsigned hi;
    int unsigned lo;
    int unsigned exp_period;
    bit          exp_timeout;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int unsigned k;
    int unsigned nv;

    vecs[0] = '{10, 10,  20, 1'b0};
    vecs[1] = '{ 3,  3,   6, 1'b0};
    vecs[2] = '{ 2,  2,   4, 1'b0};
    vecs[3] = '{ 7, 13,  20, 1'b0};
    vecs[4] = '{50, 50, 100, 1'b0};   // closing edge exactly at cnt == MAX_CYC
    vecs[5] = '{50, 51,   0, 1'b1};   // one cycle too long: timeout
    vecs[6] = '{ 2, 97,  99, 1'b0};

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("reset period",  32'(period),  32'd0);
    check("reset valid",   32'(valid),   32'd0);
    check("reset timeout", 32'(timeout), 32'd0);
    check("reset busy",    32'(busy),    32'd0);
    #2 rst_n = 1'b1;
    repeat (4) tick();
    check("idle after reset busy", 32'(busy), 32'd0);

    // Table-driven single-shot measurements
    for (int i = 0; i < 7; i++) begin
      gen_hi = vecs[i].hi;
      gen_lo = vecs[i].lo;
      gen_en = 1'b1;
      cont   = 1'b0;
      repeat (2 * (gen_hi + gen_lo)) tick();
      pulse_start();
      check("vec busy during", 32'(busy), 32'd1);
      wait_valid("vec valid seen", k);
      check("vec period",  32'(period),  vecs[i].exp_period);
      check("vec timeout", 32'(timeout), 32'(vecs[i].exp_timeout));
      tick();
      check("vec busy after", 32'(busy),  32'd0);
      check("vec valid width", 32'(valid), 32'd0);
    end

    // Timeout while waiting for the first edge: sig_in held low
    gen_en = 1'b0;
    repeat (6) tick();
    pulse_start();
    wait_valid("arm timeout seen", k);
    check("arm timeout latency", k + 1, 32'd102);
    check("arm timeout flag",    32'(timeout), 32'd1);
    check("arm timeout period",  32'(period),  32'd0);
    tick();
    check("arm timeout busy after", 32'(busy), 32'd0);

    // Continuous mode: back-to-back results, then drop cont
    gen_hi = 3;
    gen_lo = 3;
    gen_en = 1'b1;
    cont   = 1'b1;
    repeat (20) tick();
    pulse_start();
    wait_valid("cont first seen", k);
    check("cont first period", 32'(period), 32'd6);
    for (int i = 0; i < 4; i++) begin
      wait_valid("cont seen", k);
      check("cont spacing", k, 32'd6);
      check("cont period",  32'(period),  32'd6);
      check("cont timeout", 32'(timeout), 32'd0);
      check("cont busy",    32'(busy),    32'd1);
    end
    cont = 1'b0;
    wait_valid("cont last seen", k);
    check("cont last spacing", k, 32'd6);
    check("cont last period",  32'(period), 32'd6);
    check("cont last busy",    32'(busy),   32'd0);
    nv = 0;
    repeat (20) begin
      tick();
      if (valid) nv++;
    end
    check("cont no further valid", nv, 32'd0);

    // Extra start pulses during a measurement are ignored
    gen_hi = 10;
    gen_lo = 10;
    repeat (40) tick();
    pulse_start();
    k = 0;
    while (!valid && k < WAIT_LIM) begin
      start = (k % 3 == 0);
      tick();
      k++;
    end
    start = 1'b0;
    check("restart valid seen", 32'(valid),  32'd1);
    check("restart period",     32'(period), 32'd20);
    tick();
    check("restart busy after", 32'(busy), 32'd0);

    // Asynchronous reset mid-measurement
    pulse_start();
    repeat (15) tick();
    check("pre-reset busy", 32'(busy), 32'd1);
    @(posedge in_clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset period",  32'(period),  32'd0);
    check("async reset valid",   32'(valid),   32'd0);
    check("async reset timeout", 32'(timeout), 32'd0);
    check("async reset busy",    32'(busy),    32'd0);
    nv = 0;
    repeat (5) begin
      tick();
      if (valid) nv++;
    end
    #2 rst_n = 1'b1;
    repeat (50) begin
      tick();
      if (valid) nv++;
    end
    check("no valid across reset", nv, 32'd0);
    check("post-reset idle busy",  32'(busy), 32'd0);
    pulse_start();
    wait_valid("post-reset seen", k);
    check("post-reset period", 32'(period), 32'd20);

    // Randomized stimulus checked cycle by cycle against the model
    for (int r = 0; r < 3000; r++) begin
      if (r % 400 == 0) begin
        gen_hi = $urandom_range(60, 2);
        gen_lo = $urandom_range(60, 2);
      end
      start = ($urandom_range(15, 0) == 0);
      cont  = ($urandom_range(3, 0) != 0);
      tick();
    end
    start = 1'b0;
    cont  = 1'b0;
    repeat (300) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CNT_W, default 32, width of the cycle counter and of the period result.
REQ-002 Parameter MAX_CYC, default 2**CNT_W-1, counter value at which a measurement aborts with timeout; legal range 2..2**CNT_W-1.
REQ-003 in_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sig_in  input  1  slow clock to measure, asynchronous to in_clk; high and low phases each >= 2 in_clk cycles.
REQ-006 start  input  1  one-cycle request to begin a measurement.
REQ-007 cont  input  1  continuous mode; sampled at measurement completion.
REQ-008 period  output  CNT_W  last measured period in in_clk cycles, held between updates.
REQ-009 valid  output  1  one-cycle pulse when period/timeout is updated.
REQ-010 timeout  output  1  qualifies valid; 1 means aborted, no edge within MAX_CYC.
REQ-011 busy  output  1  high in ARM and MEASURE states.

Function
REQ-012 sig_in SHALL pass a 2-flop synchronizer (s1, s2) plus a delay flop s3; rise = s2 & ~s3.
REQ-013 FSM states SHALL be IDLE, ARM, MEASURE; busy = (state != IDLE), registered-equivalent, no glitches.
REQ-014 IDLE: start=1 -> ARM, cnt <= 0; start ignored in ARM and MEASURE.
REQ-015 ARM: rise -> MEASURE, cnt <= 1; otherwise cnt <= cnt+1.
REQ-016 MEASURE: no rise -> cnt <= cnt+1; rise -> period <= cnt, valid <= 1, timeout <= 0 next cycle.
REQ-017 Result SHALL equal the in_clk cycle count between consecutive detected rising edges, e.g. a 20-cycle sig_in gives period=20.
REQ-018 On MEASURE completion, cont=1 -> stay in MEASURE with cnt <= 1, so the closing edge opens the next window with no lost cycles; cont=0 -> IDLE.
REQ-019 ARM or MEASURE with cnt == MAX_CYC and no rise -> IDLE, valid <= 1, timeout <= 1, period <= 0, regardless of cont.
REQ-020 rise and cnt == MAX_CYC in the same cycle SHALL be treated as a valid edge; the edge wins.
REQ-021 valid and timeout SHALL be exactly one cycle wide; timeout = 0 whenever valid = 0.
REQ-022 Counter SHALL never wrap; MAX_CYC bounds it below 2**CNT_W.
REQ-023 Latency: sig_in edge to rise is 2-3 in_clk cycles; rise to valid is 1 cycle.
REQ-024 start arriving in the same cycle a measurement completes SHALL be ignored; the state is not IDLE then.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, cnt=0, period=0, valid=0, timeout=0, busy=0, and s1=s2=s3=0.
REQ-026 Reset mid-measurement SHALL discard the partial count without raising valid.
REQ-027 After rst_n deasserts, the block SHALL await start; the first measurement requires start.

Verification
REQ-028 sig_in toggling every 10 in_clk (period 20), start pulse, cont=0 -> one valid, period=20, timeout=0, then busy=0.
REQ-029 sig_in period 6, cont=1, start once -> valid every 6 cycles with period=6 each time, no gaps; drop cont -> returns to IDLE after the next result.
REQ-030 MAX_CYC=100, sig_in held 0, start -> valid with timeout=1 and period=0, 102 cycles after start, then busy=0.
REQ-031 Extra start pulses during MEASURE -> no restart; period still 20 for a 20-cycle input.
REQ-032 rst_n pulsed low mid-MEASURE -> outputs 0 asynchronously, no valid; a later start measures correctly.
REQ-033 Edge arriving exactly when cnt == MAX_CYC -> valid with timeout=0 and period=MAX_CYC.
